// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and FSM state type for the cache line <-> memory burst adaptor.
package cacheline_adaptor_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int N_BEATS  = S_LINE / S_BURST;

  localparam logic [1:0] LAST_BEAT = 2'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// Splits one 256-bit cache line read/writeback into a 4-beat 64-bit memory burst.
// Accept in IDLE, one beat per resp_i strobe, then a single-cycle resp_o in DONE.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [S_LINE-1:0]   line_i,
  output logic [S_LINE-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [S_BURST-1:0]  burst_i,
  output logic [S_BURST-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_cnt;
  logic [31:0]         r_addr;
  logic [S_LINE-1:0]   r_line;
  logic [S_LINE-1:0]   r_line_o;
  logic                w_last;

  assign w_last = (r_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Read has priority when both requests are raised together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (read_i)       w_state_nxt = RD;
        else if (write_i) w_state_nxt = WR;
      end
      RD:      if (resp_i && w_last) w_state_nxt = DONE;
      WR:      if (resp_i && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 2'd0;
      r_addr   <= 32'd0;
      r_line   <= '0;
      r_line_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr <= address_i;
          end else if (write_i) begin
            r_addr <= address_i;
            r_line <= line_i;
          end
        end
        RD: begin
          if (resp_i) begin
            r_line_o[r_cnt*S_BURST +: S_BURST] <= burst_i;
            r_cnt <= r_cnt + 2'd1;
          end
        end
        WR: begin
          if (resp_i) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign address_o = {r_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  assign burst_o   = r_line[r_cnt*S_BURST +: S_BURST];
  assign line_o    = r_line_o;
  assign read_o    = (r_state == RD);
  assign write_o   = (r_state == WR);
  assign resp_o    = (r_state == DONE);

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, gapped writes, back-to-back, async reset, priority.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] WB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] WC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] WD = 64'hDDDD_0000_0000_000D;

  logic [255:0] line1;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_o === 1'b1) resp_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d);
    resp_i  = 1'b1;
    burst_i = d;
    tick();
  endtask

  initial begin
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    line1 = {B4, B3, B2, B1};
    tick(); tick();
    chk("rst_read_o",  256'(read_o),  256'd0);
    chk("rst_write_o", 256'(write_o), 256'd0);
    chk("rst_resp_o",  256'(resp_o),  256'd0);
    chk("rst_addr_o",  256'(address_o), 256'd0);
    chk("rst_line_o",  line_o, 256'd0);
    chk("rst_burst_o", 256'(burst_o), 256'd0);
    rst = 1'b1;
    tick();

    // Read with no gaps; address_i toggled mid-burst
    address_i = 32'h1234_5678; read_i = 1;
    tick();
    chk("rd1_read_o", 256'(read_o), 256'd1);
    chk("rd1_addr_o", 256'(address_o), 256'h1234_5660);
    beat(B1);
    address_i = 32'hFFFF_FFFF;
    beat(B2);
    chk("rd1_addr_hold", 256'(address_o), 256'h1234_5660);
    chk("rd1_read_mid", 256'(read_o), 256'd1);
    beat(B3);
    beat(B4);
    chk("rd1_resp_o", 256'(resp_o), 256'd1);
    chk("rd1_read_done", 256'(read_o), 256'd0);
    chk("rd1_line_o", line_o, line1);
    read_i = 0; resp_i = 0;
    tick();
    chk("rd1_resp_drop", 256'(resp_o), 256'd0);
    chk("rd1_resp_cnt", 256'(resp_cnt), 256'd1);

    // Write with resp_i gaps 1,0,0,1,1,0,1; line_i toggled mid-burst
    write_i = 1; address_i = 32'h8000_0020; line_i = {WD, WC, WB, WA};
    tick();
    chk("wr_write_o", 256'(write_o), 256'd1);
    chk("wr_addr_o", 256'(address_o), 256'h8000_0020);
    chk("wr_burst_A", 256'(burst_o), 256'(WA));
    line_i = '1; address_i = 32'h0;
    resp_i = 1; tick(); chk("wr_burst_B", 256'(burst_o), 256'(WB));
    resp_i = 0; tick(); chk("wr_hold_B1", 256'(burst_o), 256'(WB));
    resp_i = 0; tick(); chk("wr_hold_B2", 256'(burst_o), 256'(WB));
    chk("wr_addr_hold", 256'(address_o), 256'h8000_0020);
    resp_i = 1; tick(); chk("wr_burst_C", 256'(burst_o), 256'(WC));
    resp_i = 1; tick(); chk("wr_burst_D", 256'(burst_o), 256'(WD));
    resp_i = 0; tick(); chk("wr_hold_D", 256'(burst_o), 256'(WD));
    chk("wr_write_mid", 256'(write_o), 256'd1);
    chk("wr_no_resp_early", 256'(resp_o), 256'd0);
    resp_i = 1; tick();
    chk("wr_resp_o", 256'(resp_o), 256'd1);
    chk("wr_write_done", 256'(write_o), 256'd0);
    chk("wr_line_o_kept", line_o, line1);
    write_i = 0; resp_i = 0;
    tick();
    chk("wr_resp_cnt", 256'(resp_cnt), 256'd2);

    // Back-to-back: read, then write raised during DONE
    read_i = 1; address_i = 32'h0000_1000;
    tick();
    beat(B4); beat(B3); beat(B2); beat(B1);
    chk("bb_rd_resp", 256'(resp_o), 256'd1);
    chk("bb_rd_line", line_o, {B1, B2, B3, B4});
    read_i = 0; resp_i = 0; write_i = 1; line_i = {WA, WB, WC, WD}; address_i = 32'h0000_2040;
    tick();
    chk("bb_gap_read", 256'(read_o), 256'd0);
    chk("bb_gap_write", 256'(write_o), 256'd0);
    chk("bb_gap_resp", 256'(resp_o), 256'd0);
    tick();
    chk("bb_wr_write_o", 256'(write_o), 256'd1);
    chk("bb_wr_burst0", 256'(burst_o), 256'(WD));
    chk("bb_wr_addr", 256'(address_o), 256'h0000_2040);
    beat(WD); beat(WC); beat(WB); beat(WA);
    chk("bb_wr_resp", 256'(resp_o), 256'd1);
    write_i = 0; resp_i = 0;
    tick();
    chk("bb_resp_cnt", 256'(resp_cnt), 256'd4);

    // Reset asserted after beat 2 of a read
    read_i = 1; address_i = 32'h0000_3000;
    tick();
    beat(B1); beat(B2);
    resp_i = 0;
    #1 rst = 1'b0;
    #1;
    chk("arst_read_o", 256'(read_o), 256'd0);
    chk("arst_addr_o", 256'(address_o), 256'd0);
    chk("arst_line_o", line_o, 256'd0);
    chk("arst_resp_o", 256'(resp_o), 256'd0);
    read_i = 0;
    tick(); tick();
    chk("arst_resp_cnt", 256'(resp_cnt), 256'd4);
    rst = 1'b1;
    tick();
    read_i = 1; address_i = 32'h0000_3000;
    tick();
    beat(B3); beat(B4); beat(B1); beat(B2);
    chk("post_rst_resp", 256'(resp_o), 256'd1);
    chk("post_rst_line", line_o, {B2, B1, B4, B3});
    read_i = 0; resp_i = 0;
    tick();
    chk("post_rst_resp_cnt", 256'(resp_cnt), 256'd5);

    // Both requests high: read must win
    read_i = 1; write_i = 1; address_i = 32'h0000_4000; line_i = '1;
    $display("note: protocol violation driven, read_i and write_i both high");
    tick();
    chk("prio_read_o", 256'(read_o), 256'd1);
    chk("prio_write_o", 256'(write_o), 256'd0);
    beat(B1); beat(B1); beat(B2); beat(B2);
    chk("prio_line", line_o, {B2, B2, B1, B1});
    read_i = 0; write_i = 0; resp_i = 0;
    tick();

    // Stray resp_i in IDLE
    resp_i = 1; burst_i = B4;
    tick();
    chk("idle_resp_read_o", 256'(read_o), 256'd0);
    chk("idle_resp_write_o", 256'(write_o), 256'd0);
    chk("idle_resp_resp_o", 256'(resp_o), 256'd0);
    resp_i = 0;
    tick();
    chk("idle_resp_line", line_o, {B2, B2, B1, B1});
    chk("idle_resp_cnt", 256'(resp_cnt), 256'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
